// File: rtl/headgen_pipe_s2.sv
// headgen_pipe_s2: second stage of the header generator. Executes a 9-bit
// microcode stream into header bytes, substituting the IPv4 total-length and
// header-checksum bytes from values captured at the first word of a header.
// Two enabled edges from a word on in_0 to the matching output byte.
module headgen_pipe_s2 #(
    parameter int MAX_HDR_BYTES = 64,
    parameter int CNT_W         = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enableout,
    input  logic        in_valid,
    input  logic [8:0]  in_0,
    input  logic [15:0] in_1,
    input  logic [15:0] in_2,
    input  logic [15:0] in_3,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_HDR_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Header FSM and byte counter
    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_byteCnt;
    logic [CNT_W-1:0]   w_nextCnt;

    // Stage A: decoded action for the word accepted on this edge
    logic               r_aEmit;
    logic               r_aSof;
    logic               r_aEof;
    logic               r_aAbort;
    logic [8:0]         r_aWord;
    logic [15:0]        r_totalLen;
    logic [16:0]        r_sum17;

    // Stage B: registered outputs
    logic [7:0]         r_outData;
    logic               r_outValid;
    logic               r_outSof;
    logic               r_outEof;
    logic               r_outErr;

    // Combinational decode / arithmetic
    logic               w_isEnd;
    logic               w_atLimit;
    logic               w_emit;
    logic               w_sof;
    logic               w_eof;
    logic               w_abort;
    logic               w_capture;
    logic [15:0]        w_totalLen;
    logic [16:0]        w_sum17;
    logic [15:0]        w_fold;
    logic [15:0]        w_chsum;
    logic [7:0]         w_outByte;
    logic               w_advance;

    assign w_advance  = enableout;
    assign w_isEnd    = in_0[8] && (in_0[2:0] == 3'd7);
    assign w_atLimit  = (r_byteCnt == CNT_LIMIT);

    // Length and checksum terms derived from the live stage-1 values; only
    // latched when a header starts.
    assign w_totalLen = in_1 + in_2;
    assign w_sum17    = {1'b0, in_3} + {1'b0, w_totalLen};

    // The single end-around-carry fold cannot overflow again.
    assign w_fold     = r_sum17[15:0] + {15'd0, r_sum17[16]};
    assign w_chsum    = ~w_fold;

    // State register and byte counter, advancing only when the pipe moves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_byteCnt <= '0;
        end else if (w_advance) begin
            r_state   <= w_nextState;
            r_byteCnt <= w_nextCnt;
        end
    end

    // Next-state logic and stage-A action decode for the incoming word
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_byteCnt;
        w_emit      = 1'b0;
        w_sof       = 1'b0;
        w_eof       = 1'b0;
        w_abort     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_isEnd) begin
                        w_eof = 1'b1;
                    end else begin
                        w_emit      = 1'b1;
                        w_sof       = 1'b1;
                        w_capture   = 1'b1;
                        w_nextCnt   = CNT_ONE;
                        w_nextState = HDR;
                    end
                end
            end
            HDR: begin
                if (in_valid) begin
                    if (w_isEnd) begin
                        w_eof       = 1'b1;
                        w_nextState = IDLE;
                    end else if (w_atLimit) begin
                        w_eof       = 1'b1;
                        w_abort     = 1'b1;
                        w_nextState = DRAIN;
                    end else begin
                        w_emit    = 1'b1;
                        w_nextCnt = r_byteCnt + CNT_ONE;
                    end
                end
            end
            DRAIN: begin
                if (in_valid && w_isEnd) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Stage A: register the word and its action; latch lengths at header start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aEmit    <= 1'b0;
            r_aSof     <= 1'b0;
            r_aEof     <= 1'b0;
            r_aAbort   <= 1'b0;
            r_aWord    <= '0;
            r_totalLen <= '0;
            r_sum17    <= '0;
        end else if (w_advance) begin
            r_aEmit  <= w_emit;
            r_aSof   <= w_sof;
            r_aEof   <= w_eof;
            r_aAbort <= w_abort;
            r_aWord  <= in_0;
            if (w_capture) begin
                r_totalLen <= w_totalLen;
                r_sum17    <= w_sum17;
            end
        end
    end

    // Byte selection for the stage-A word: literal or substituted field
    always_comb begin
        w_outByte = 8'h00;
        if (!r_aWord[8]) begin
            w_outByte = r_aWord[7:0];
        end else begin
            case (r_aWord[2:0])
                3'd0:    w_outByte = r_totalLen[15:8];
                3'd1:    w_outByte = r_totalLen[7:0];
                3'd2:    w_outByte = w_chsum[15:8];
                3'd3:    w_outByte = w_chsum[7:0];
                default: w_outByte = 8'h00;
            endcase
        end
    end

    // Stage B: output registers; data holds between bytes, error is sticky
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_outSof   <= 1'b0;
            r_outEof   <= 1'b0;
            r_outErr   <= 1'b0;
        end else if (w_advance) begin
            r_outValid <= r_aEmit;
            r_outSof   <= r_aSof;
            r_outEof   <= r_aEof;
            if (r_aEmit) begin
                r_outData <= w_outByte;
            end
            if (r_aSof) begin
                r_outErr <= 1'b0;
            end else if (r_aAbort) begin
                r_outErr <= 1'b1;
            end
        end
    end

    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign out_sof   = r_outSof;
    assign out_eof   = r_outEof;
    assign out_err   = r_outErr;

endmodule

// File: tb/tb_headgen_pipe_s2.sv
// Scoreboard bench for headgen_pipe_s2: a behavioural header model queues the
// expected output events; a monitor pops and compares on every enabled edge.
module tb_headgen_pipe_s2;

    localparam int MAXB = 4;
    localparam logic [8:0] OP_END = 9'h107;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enableout = 1'b0;
    logic        in_valid = 1'b0;
    logic [8:0]  in_0 = '0;
    logic [15:0] in_1 = '0;
    logic [15:0] in_2 = '0;
    logic [15:0] in_3 = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        out_err;

    headgen_pipe_s2 #(
        .MAX_HDR_BYTES(MAXB),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enableout(enableout),
        .in_valid(in_valid),
        .in_0(in_0),
        .in_1(in_1),
        .in_2(in_2),
        .in_3(in_3),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_sof(out_sof),
        .out_eof(out_eof),
        .out_err(out_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        int         slot;
        bit         isEof;
        bit         sof;
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t expQ[$];

    int testCount = 0;
    int failCount = 0;

    // Monitor-owned view of the output stream
    int          edgeIdx = 0;
    logic        expErr = 1'b0;
    logic [7:0]  expLastData = 8'h00;
    logic [11:0] lastVec = 12'h000;

    // Reference model state: 0 idle, 1 inside a header, 2 draining after abort
    int          mMode = 0;
    int          mCount = 0;
    logic [15:0] mTot = '0;
    logic [15:0] mChk = '0;
    logic        mErr = 1'b0;

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got {valid,sof,eof,err,data}=%03h, expected %03h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] refByte(input logic [8:0] w);
        if (!w[8]) return w[7:0];
        case (w[2:0])
            3'd0:    return mTot[15:8];
            3'd1:    return mTot[7:0];
            3'd2:    return mChk[15:8];
            3'd3:    return mChk[7:0];
            default: return 8'h00;
        endcase
    endfunction

    task automatic pushExp(input bit isEof, input bit sof, input bit err, input logic [7:0] data);
        exp_t e;
        e.slot  = edgeIdx;
        e.isEof = isEof;
        e.sof   = sof;
        e.err   = err;
        e.data  = data;
        expQ.push_back(e);
    endtask

    // Header rules applied to one accepted word, with plain arithmetic
    task automatic modelStep(input bit v, input logic [8:0] w, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] c);
        int unsigned s;
        bit isEnd;
        if (!v) return;
        isEnd = w[8] && (w[2:0] == 3'd7);
        if (mMode == 0) begin
            if (isEnd) begin
                pushExp(1, 0, mErr, 8'h00);
            end else begin
                s = (32'(a) + 32'(b)) % 65536;
                mTot = s[15:0];
                s = 32'(c) + 32'(mTot);
                s = (s % 65536) + (s / 65536);
                mChk = ~s[15:0];
                mErr = 1'b0;
                mCount = 1;
                mMode = 1;
                pushExp(0, 1, 0, refByte(w));
            end
        end else if (mMode == 1) begin
            if (isEnd) begin
                pushExp(1, 0, mErr, 8'h00);
                mMode = 0;
            end else if (mCount == MAXB) begin
                mErr = 1'b1;
                pushExp(1, 0, 1, 8'h00);
                mMode = 2;
            end else begin
                mCount++;
                pushExp(0, 0, mErr, refByte(w));
            end
        end else begin
            if (isEnd) mMode = 0;
        end
    endtask

    // Drive one slot at the current falling edge, then move to the next one
    task automatic applyStimulus(input bit en, input bit v, input logic [8:0] w,
                                 input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        enableout = en;
        in_valid  = v;
        in_0      = w;
        in_1      = a;
        in_2      = b;
        in_3      = c;
        if (en) modelStep(v, w, a, b, c);
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic applyReset();
        rst       = 1'b0;
        enableout = 1'b0;
        in_valid  = 1'b0;
        in_0      = '0;
        #1;
        checkOutput("reset_outputs", {out_valid, out_sof, out_eof, out_err, out_data}, 12'h000);
        mMode  = 0;
        mCount = 0;
        mTot   = '0;
        mChk   = '0;
        mErr   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compare the DUT against the queue on every enabled edge
    initial begin : monitor
        logic        en;
        logic        rs;
        logic [11:0] actVec;
        logic [11:0] expVec;
        int          slotOut;
        bit          hit;
        exp_t        e;
        forever begin
            @(posedge clk);
            en = enableout;
            rs = rst;
            #1;
            actVec = {out_valid, out_sof, out_eof, out_err, out_data};
            if (!rs || !rst) begin
                expQ.delete();
                edgeIdx     = 0;
                expErr      = 1'b0;
                expLastData = 8'h00;
                lastVec     = 12'h000;
            end else if (!en) begin
                checkOutput("freeze", actVec, lastVec);
                lastVec = actVec;
            end else begin
                slotOut = edgeIdx - 1;
                edgeIdx++;
                while (expQ.size() > 0 && expQ[0].slot < slotOut) begin
                    e = expQ.pop_front();
                    testCount++;
                    failCount++;
                    $display("[TB] FAIL missing_output: slot %0d never appeared, got %03h at %0t", e.slot, actVec, $time);
                end
                hit = 0;
                if (expQ.size() > 0 && expQ[0].slot == slotOut) begin
                    e = expQ.pop_front();
                    hit = 1;
                end
                if (hit && e.isEof) begin
                    expErr = e.err;
                    expVec = {1'b0, 1'b0, 1'b1, e.err, expLastData};
                    checkOutput("eof_strobe", actVec, expVec);
                end else if (hit) begin
                    expErr      = e.err;
                    expLastData = e.data;
                    expVec = {1'b1, e.sof, 1'b0, e.err, e.data};
                    checkOutput("data_byte", actVec, expVec);
                end else begin
                    expVec = {1'b0, 1'b0, 1'b0, expErr, expLastData};
                    checkOutput("idle_cycle", actVec, expVec);
                end
                lastVec = actVec;
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin : stimulus
        logic [8:0] w;
        int r;
        #2;
        applyReset();

        // Plain literals with an END
        applyStimulus(1, 1, 9'h045, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 1, 9'h000, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 1, OP_END, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 0, 9'h000, 16'h0, 16'h0, 16'h0);

        // Total length substitution: 0x05DC + 0x0014
        applyStimulus(1, 1, 9'h100, 16'h05DC, 16'h0014, 16'h0000);
        applyStimulus(1, 1, 9'h101, 16'h05DC, 16'h0014, 16'h0000);
        applyStimulus(1, 1, OP_END, 16'h05DC, 16'h0014, 16'h0000);

        // Checksum substitution with an end-around carry
        applyStimulus(1, 1, 9'h102, 16'h05DC, 16'h0014, 16'hFFFF);
        applyStimulus(1, 1, 9'h103, 16'h05DC, 16'h0014, 16'hFFFF);
        applyStimulus(1, 1, 9'h1FC, 16'h05DC, 16'h0014, 16'hFFFF);
        applyStimulus(1, 1, OP_END, 16'h05DC, 16'h0014, 16'hFFFF);

        // Enable stalls inside a four-byte header; junk words while frozen
        applyStimulus(1, 1, 9'h011, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 1, 9'h022, 16'h0, 16'h0, 16'h0);
        applyStimulus(0, 1, 9'h0EE, 16'h0, 16'h0, 16'h0);
        applyStimulus(0, 1, OP_END, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 1, 9'h033, 16'h0, 16'h0, 16'h0);
        applyStimulus(0, 0, 9'h0AA, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 1, 9'h044, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 1, OP_END, 16'h0, 16'h0, 16'h0);

        // Length inputs change mid-header; captured value must be used
        applyStimulus(1, 1, 9'h045, 16'h0100, 16'h0014, 16'h1234);
        applyStimulus(1, 1, 9'h100, 16'h0200, 16'h0014, 16'h1234);
        applyStimulus(1, 1, 9'h101, 16'h0200, 16'h0020, 16'h4321);
        applyStimulus(1, 1, OP_END, 16'h0200, 16'h0020, 16'h4321);

        // Abort: six literals exceed the limit, then empty header keeps err
        for (int i = 0; i < 6; i++) begin
            w = 9'(8'h60 + i);
            applyStimulus(1, 1, w, 16'h0, 16'h0, 16'h0);
        end
        applyStimulus(1, 0, 9'h000, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 1, OP_END, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 1, OP_END, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 1, 9'h0A5, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 1, OP_END, 16'h0, 16'h0, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) begin
                w = OP_END;
                w[7:3] = 5'($urandom);
            end else if (r < 55) begin
                w = {1'b1, 5'($urandom), 3'($urandom_range(0, 6))};
            end else begin
                w = {1'b0, 8'($urandom)};
            end
            applyStimulus($urandom_range(0, 99) < 85, $urandom_range(0, 9) < 8, w,
                          16'($urandom), 16'($urandom), 16'($urandom));
        end
        applyStimulus(1, 1, OP_END, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 1, OP_END, 16'h0, 16'h0, 16'h0);

        // Reset in the middle of a header discards it without an eof
        applyStimulus(1, 1, 9'h0C1, 16'h0010, 16'h0020, 16'h0);
        applyStimulus(1, 1, 9'h0C2, 16'h0010, 16'h0020, 16'h0);
        applyStimulus(1, 1, 9'h0C3, 16'h0010, 16'h0020, 16'h0);
        #3;
        applyReset();
        applyStimulus(1, 1, 9'h101, 16'h0010, 16'h0020, 16'h0);
        applyStimulus(1, 1, 9'h0D4, 16'h0010, 16'h0020, 16'h0);
        applyStimulus(1, 1, OP_END, 16'h0010, 16'h0020, 16'h0);

        // Flush the pipe and confirm every expected event was seen
        repeat (4) applyStimulus(1, 0, 9'h000, 16'h0, 16'h0, 16'h0);
        testCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL queue_drain: %0d events still pending, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
